// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the riscv64i core: the stage-register
// state encoding, the data width used for late side fields, and payload
// widths derived from the packed stage structs.
package pipeline_pkg;

    localparam int XLEN       = 64;
    localparam int DATA_WIDTH = 64;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic            predTaken;
    } if_id_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1Val;
        logic [XLEN-1:0] rs2Val;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic [7:0]      ctrl;
    } id_ex_t;

    typedef struct packed {
        logic [XLEN-1:0] aluResult;
        logic [XLEN-1:0] storeData;
        logic [4:0]      rd;
        logic [3:0]      memCtrl;
        logic            regWrite;
    } ex_mem_t;

    localparam int IF_ID_W  = $bits(if_id_t);
    localparam int ID_EX_W  = $bits(id_ex_t);
    localparam int EX_MEM_W = $bits(ex_mem_t);

endpackage

// File: rtl/pipe_stage_skid_ctrl.sv
// Handshake controller for the skid stage register. Tracks how many entries
// the stage holds (EMPTY/ONE/FULL) and tells the datapath which register to
// load each cycle. Upstream ready is registered from the next state so it
// never depends combinationally on downstream ready.
import pipeline_pkg::*;

module pipe_stage_skid_ctrl (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    input  logic in_valid_i,
    input  logic out_ready_i,
    output logic load_main_o,
    output logic load_skid_o,
    output logic main_from_skid_o,
    output logic in_ready_o,
    output logic out_valid_o
);

    skid_state_t state_q, state_d;
    logic        in_ready_q;
    logic        accept;
    logic        consume;

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = (state_q != EMPTY);
    assign accept      = in_valid_i && in_ready_q;
    assign consume     = out_valid_o && out_ready_i;

    // State and registered upstream ready; ready reflects the state being entered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != FULL);
        end
    end

    // Next state and register load strobes; flush overrides any transfer.
    always_comb begin
        state_d          = state_q;
        load_main_o      = 1'b0;
        load_skid_o      = 1'b0;
        main_from_skid_o = 1'b0;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d     = ONE;
                        load_main_o = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        load_main_o = 1'b1;
                    end else if (accept) begin
                        state_d     = FULL;
                        load_skid_o = 1'b1;
                    end else if (consume) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (consume) begin
                        state_d          = ONE;
                        main_from_skid_o = 1'b1;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with valid/ready handshake, 2-entry skid
// buffer and synchronous flush. Carries an opaque packed stage payload plus
// a late side field, presented as {late, payload}.
// Optional stall counter enabled by defining PIPE_STAGE_PERF_EN.
import pipeline_pkg::*;

module pipe_stage_skid #(
    parameter int PAYLOAD_W = 256,
    parameter int LATE_W    = DATA_WIDTH
`ifdef PIPE_STAGE_PERF_EN
    ,
    parameter int CNT_W     = 32
`endif
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [PAYLOAD_W-1:0]        in_payload,
    input  logic [LATE_W-1:0]           in_late,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [PAYLOAD_W+LATE_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]            stall_cycles
`endif
);

    localparam int ENTRY_W = PAYLOAD_W + LATE_W;

    logic [ENTRY_W-1:0] main_q;
    logic [ENTRY_W-1:0] skid_q;
    logic [ENTRY_W-1:0] entry_in;
    logic               load_main;
    logic               load_skid;
    logic               main_from_skid;

    assign entry_in = {in_late, in_payload};
    assign out_data = main_q;

    pipe_stage_skid_ctrl u_ctrl (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .flush_i         (flush),
        .in_valid_i      (in_valid),
        .out_ready_i     (out_ready),
        .load_main_o     (load_main),
        .load_skid_o     (load_skid),
        .main_from_skid_o(main_from_skid),
        .in_ready_o      (in_ready),
        .out_valid_o     (out_valid)
    );

    // Head entry: takes the incoming entry or promotes the skid entry; holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
        end else if (load_main) begin
            main_q <= entry_in;
        end else if (main_from_skid) begin
            main_q <= skid_q;
        end
    end

    // Skid entry: catches the one entry accepted while the head is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_q <= '0;
        end else if (load_skid) begin
            skid_q <= entry_in;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_q;

    assign stall_cycles = stall_q;

    // Saturating count of cycles the head entry waits on downstream; survives flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Testbench for pipe_stage_skid: reset behaviour, a table of hand-computed
// handshake vectors, randomized traffic against a queue model, and an
// asynchronous reset in the middle of operation.
module tb_pipe_stage_skid;

    localparam int PW = 16;
    localparam int LW = 8;
    localparam int DW = PW + LW;
`ifdef PIPE_STAGE_PERF_EN
    localparam int CW = 4;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_payload;
    logic [LW-1:0] in_late;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
    logic [CW-1:0] stall_cycles;
`endif

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] modelQ[$];

    typedef struct {
        logic          flush;
        logic          inValid;
        logic          outReady;
        logic [PW-1:0] payload;
        logic [LW-1:0] late;
        logic          expValid;
        logic          expReady;
        logic          checkData;
        logic [DW-1:0] expData;
    } vector_t;

    vector_t vectors[13];

    always #5 clk = ~clk;

    pipe_stage_skid #(
        .PAYLOAD_W(PW),
        .LATE_W   (LW)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .CNT_W    (CW)
`endif
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_payload  (in_payload),
        .in_late     (in_late),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic f, input logic iv, input logic ordy,
                                 input logic [PW-1:0] p, input logic [LW-1:0] l);
        flush      = f;
        in_valid   = iv;
        out_ready  = ordy;
        in_payload = p;
        in_late    = l;
    endtask

    // Queue model: capacity two, ready while not full, flush empties it.
    task automatic modelStep();
        bit acc;
        bit con;
        if (flush) begin
            modelQ.delete();
        end else begin
            acc = in_valid && (modelQ.size() < 2);
            con = out_ready && (modelQ.size() > 0);
            if (con) void'(modelQ.pop_front());
            if (acc) modelQ.push_back({in_late, in_payload});
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, "_valid"}, {31'd0, out_valid}, {31'd0, modelQ.size() > 0});
        checkValue({tag, "_ready"}, {31'd0, in_ready}, {31'd0, modelQ.size() < 2});
        if (modelQ.size() > 0)
            checkValue({tag, "_data"}, {8'd0, out_data}, {8'd0, modelQ[0]});
    endtask

    function automatic vector_t mkVec(input logic f, input logic iv, input logic ordy,
                                      input logic [PW-1:0] p, input logic [LW-1:0] l,
                                      input logic ev, input logic er, input logic cd,
                                      input logic [DW-1:0] ed);
        vector_t v;
        v.flush = f; v.inValid = iv; v.outReady = ordy; v.payload = p; v.late = l;
        v.expValid = ev; v.expReady = er; v.checkData = cd; v.expData = ed;
        return v;
    endfunction

    initial begin
        // Hand-computed vectors starting from EMPTY; expectations are the outputs after the edge.
        vectors[0]  = mkVec(0, 1, 1, 16'd1, 8'hA0, 1, 1, 1, {8'hA0, 16'd1});
        vectors[1]  = mkVec(0, 1, 1, 16'd2, 8'hA1, 1, 1, 1, {8'hA1, 16'd2});
        vectors[2]  = mkVec(0, 1, 1, 16'd3, 8'hA2, 1, 1, 1, {8'hA2, 16'd3});
        vectors[3]  = mkVec(0, 1, 0, 16'd4, 8'hA3, 1, 0, 1, {8'hA2, 16'd3});
        vectors[4]  = mkVec(0, 1, 0, 16'd5, 8'hA4, 1, 0, 1, {8'hA2, 16'd3});
        vectors[5]  = mkVec(0, 1, 1, 16'd5, 8'hA4, 1, 1, 1, {8'hA3, 16'd4});
        vectors[6]  = mkVec(0, 0, 1, 16'd0, 8'h00, 0, 1, 0, '0);
        vectors[7]  = mkVec(0, 1, 0, 16'd6, 8'hA5, 1, 1, 1, {8'hA5, 16'd6});
        vectors[8]  = mkVec(0, 1, 0, 16'd7, 8'hA6, 1, 0, 1, {8'hA5, 16'd6});
        vectors[9]  = mkVec(1, 1, 1, 16'd8, 8'hA7, 0, 1, 0, '0);
        vectors[10] = mkVec(0, 0, 1, 16'd0, 8'h00, 0, 1, 0, '0);
        vectors[11] = mkVec(0, 1, 1, 16'd9, 8'hA7, 1, 1, 1, {8'hA7, 16'd9});
        vectors[12] = mkVec(0, 0, 1, 16'd0, 8'h00, 0, 1, 0, '0);

        // Reset held with in_valid high must keep the stage empty.
        rst_n = 1'b0;
        applyStimulus(0, 1, 0, 16'h0055, 8'h11);
        repeat (3) @(negedge clk);
        checkValue("rst_valid", {31'd0, out_valid}, 32'd0);
        checkValue("rst_ready", {31'd0, in_ready}, 32'd1);
        checkValue("rst_data", {8'd0, out_data}, 32'd0);
`ifdef PIPE_STAGE_PERF_EN
        checkValue("rst_stall", {28'd0, stall_cycles}, 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        checkValue("first_valid", {31'd0, out_valid}, 32'd1);
        checkValue("first_data", {8'd0, out_data}, {8'd0, 8'h11, 16'h0055});
        applyStimulus(0, 0, 1, 16'd0, 8'd0);
        @(negedge clk);
        checkValue("drain_valid", {31'd0, out_valid}, 32'd0);

        // Table-driven handshake vectors.
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vectors[i].flush, vectors[i].inValid, vectors[i].outReady,
                          vectors[i].payload, vectors[i].late);
            @(negedge clk);
            checkValue($sformatf("vec%0d_valid", i), {31'd0, out_valid}, {31'd0, vectors[i].expValid});
            checkValue($sformatf("vec%0d_ready", i), {31'd0, in_ready}, {31'd0, vectors[i].expReady});
            if (vectors[i].checkData)
                checkValue($sformatf("vec%0d_data", i), {8'd0, out_data}, {8'd0, vectors[i].expData});
        end

        // Randomized traffic against the queue model.
        modelQ.delete();
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 1) == 1), PW'($urandom), LW'($urandom));
            modelStep();
            @(negedge clk);
            checkOutput($sformatf("rand%0d", i));
        end

        // Asynchronous reset while full: outputs clear without a clock edge.
        applyStimulus(0, 1, 0, 16'h0101, 8'h22);
        @(negedge clk);
        applyStimulus(0, 1, 0, 16'h0202, 8'h33);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkValue("midrst_valid", {31'd0, out_valid}, 32'd0);
        checkValue("midrst_ready", {31'd0, in_ready}, 32'd1);
        checkValue("midrst_data", {8'd0, out_data}, 32'd0);
        @(negedge clk);
        applyStimulus(0, 1, 0, 16'h0404, 8'h44);
        rst_n = 1'b1;
        @(negedge clk);
        checkValue("postrst_valid", {31'd0, out_valid}, 32'd1);
        checkValue("postrst_ready", {31'd0, in_ready}, 32'd1);
        checkValue("postrst_data", {8'd0, out_data}, {8'd0, 8'h44, 16'h0404});

`ifdef PIPE_STAGE_PERF_EN
        // Stall counter saturates, survives flush, clears on reset.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 1, 0, 16'h0707, 8'h77);
        @(negedge clk);
        applyStimulus(0, 0, 0, 16'd0, 8'd0);
        repeat (20) @(negedge clk);
        checkValue("stall_sat", {28'd0, stall_cycles}, 32'd15);
        applyStimulus(1, 0, 0, 16'd0, 8'd0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 16'd0, 8'd0);
        @(negedge clk);
        checkValue("stall_flush", {28'd0, stall_cycles}, 32'd15);
        rst_n = 1'b0;
        #1;
        checkValue("stall_reset", {28'd0, stall_cycles}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
